// File: rtl/async_fifo_core.sv
// Single-clock FWFT FIFO: zero-cycle read latency, writes dropped when full, reads ignored when empty.
// Define ASYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module async_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    localparam int ADDR      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR:0]         count
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    // DEPTH is a power of two, so a full count is just the wrap bit set.
    localparam logic [ADDR:0] FULL_CNT = {1'b1, {ADDR{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR:0]         wr_ptr;
    logic [ADDR:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign wr_acc    = write_en && !full;
    assign rd_acc    = read_en && !empty;
    assign read_data = empty ? '0 : mem[rd_ptr[ADDR-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never cleared; the reset edge must not write either.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) mem[wr_ptr[ADDR-1:0]] <= write_data;
    end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && full)  overflow  <= 1'b1;
            if (read_en && empty)  underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Randomized self-checking bench for async_fifo_core against a queue reference model.
module tb_async_fifo_core;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write_en = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          read_en = 1'b0;
    logic [DW-1:0] read_data;
    logic          full;
    logic          empty;
    logic [3:0]    count;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
    logic          ovf_m = 1'b0;
    logic          unf_m = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    async_fifo_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .write_en(write_en),
        .write_data(write_data),
        .read_en(read_en),
        .read_data(read_data),
        .full(full),
        .empty(empty),
        .count(count)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    function automatic logic [DW-1:0] head_m();
        return (q.size() == 0) ? '0 : q[0];
    endfunction

    function automatic logic [3:0] count_m();
        return 4'(q.size());
    endfunction

    // Apply one cycle of inputs, let the edge happen, then update the model.
    task automatic cycle(input logic rst, input logic we, input logic [DW-1:0] wd, input logic re);
        bit was_full;
        bit was_empty;
        reset = rst; write_en = we; write_data = wd; read_en = re;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (rst) begin
            q.delete();
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
            ovf_m = 1'b0;
            unf_m = 1'b0;
`endif
        end else begin
            if (re && !was_empty) void'(q.pop_front());
            if (we && !was_full) q.push_back(wd);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
            if (we && was_full)  ovf_m = 1'b1;
            if (re && was_empty) unf_m = 1'b1;
`endif
        end
        #1;
        reset = 1'b0; write_en = 1'b0; read_en = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 8'h5A, 1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data: got %h want 00", read_data); end
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_early[%0d]: got %b want 0", i, full); end
            checks++; if (count !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            cycle(0, 1, 8'(i * 8'h44), 0);
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count_final: got %0d want 8", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", empty); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            read_en = 1'b1;
            #1;
            checks++; if (read_data !== 8'(i * 8'h44)) begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, read_data, 8'(i * 8'h44)); end
            cycle(0, 0, 0, 1);
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'(i * 8'h44), 0);
        cycle(0, 1, 8'hAA, 0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", count); end
        checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL ovf_head: got %h want 00", read_data); end
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
`endif
        // Full with read and write together: read proceeds, write is dropped.
        cycle(0, 1, 8'hBB, 1);
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL ovf_rw_count: got %0d want 7", count); end
        checks++; if (read_data !== 8'h44) begin errors++; $display("FAIL ovf_rw_head: got %h want 44", read_data); end
        while (q.size() > 0) begin
            checks++; if (read_data !== head_m()) begin errors++; $display("FAIL ovf_drain: got %h want %h", read_data, head_m()); end
            cycle(0, 0, 0, 1);
        end
    endtask

    task automatic test_underflow();
        cycle(0, 0, 0, 1);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL unf_count: got %0d want 0", count); end
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b want 1", underflow); end
`endif
        cycle(0, 1, 8'h3C, 1);
        checks++; if (count !== 4'd1 || read_data !== 8'h3C) begin errors++; $display("FAIL unf_write_accept: got %0d/%h want 1/3c", count, read_data); end
        cycle(0, 1, 8'h11, 0);
        cycle(0, 1, 8'h22, 0);
        cycle(0, 1, 8'h33, 1);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL simul_count: got %0d want 3", count); end
        checks++; if (read_data !== 8'h11) begin errors++; $display("FAIL simul_head: got %h want 11", read_data); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        while (q.size() > 0) cycle(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            cycle(0, 1, d, 0);
            checks++; if (read_data !== d) begin errors++; $display("FAIL pair_data[%0d]: got %h want %h", i, read_data, d); end
            cycle(0, 0, 0, 1);
        end
        for (int i = 0; i < 300; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            checks++;
            if (read_data !== head_m() || count !== count_m() || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
                errors++;
                $display("FAIL random[%0d]: got data=%h cnt=%0d f=%b e=%b want data=%h cnt=%0d", i, read_data, count, full, empty, head_m(), count_m());
            end
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
            checks++; if ({overflow, underflow} !== {ovf_m, unf_m}) begin errors++; $display("FAIL random_flags[%0d]: got %b want %b", i, {overflow, underflow}, {ovf_m, unf_m}); end
`endif
        end
    endtask

    task automatic test_mid_reset();
        while (q.size() > 5) cycle(0, 0, 0, 1);
        while (q.size() < 5) cycle(0, 1, 8'($urandom), 0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL midrst_pre_count: got %0d want 5", count); end
        cycle(1, 1, 8'h77, 1);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1 || read_data !== 8'h00) begin errors++; $display("FAIL midrst_empty: got e=%b data=%h want 1/00", empty, read_data); end
        cycle(0, 1, 8'h99, 0);
        checks++; if (count !== 4'd1 || read_data !== 8'h99) begin errors++; $display("FAIL midrst_after: got %0d/%h want 1/99", count, read_data); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
